// File: rtl/top_pkg.sv
// Shared constants, state encoding and helpers for the byte-serial input framer.
package top_pkg;

  localparam int unsigned SALT_BYTES = 16;
  localparam int unsigned PW_BYTES   = 15;
  localparam int unsigned MSG_BYTES  = 16;
  localparam int unsigned KEY_LEN    = SALT_BYTES + PW_BYTES;

  localparam int unsigned SALT_W = 8 * SALT_BYTES;
  localparam int unsigned PW_W   = 8 * PW_BYTES;
  localparam int unsigned MSG_W  = 8 * MSG_BYTES;
  localparam int unsigned CNT_W  = 5;

  localparam logic KIND_KEY = 1'b0;
  localparam logic KIND_MSG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    HOLD,
    WAIT
  } state_e;

  // Number of bytes in a burst for the given phase.
  function automatic logic [CNT_W-1:0] burst_len(input logic phase);
    return (phase == KIND_MSG) ? CNT_W'(MSG_BYTES) : CNT_W'(KEY_LEN);
  endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// MSB-first byte shift register with load enable; exposes its next value so the
// owner can capture a completed block on the same edge as the final byte.
module byte_shift_reg #(
  parameter int unsigned BYTES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [7:0]         din_i,
  output logic [8*BYTES-1:0] nxt_c
);

  localparam int unsigned W = 8 * BYTES;

  logic [W-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (en_i) shift_d = {shift_q[W-9:0], din_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift_q <= '0;
    else     shift_q <= shift_d;
  end

  assign nxt_c = shift_d;

endmodule

// File: rtl/top_input_framer.sv
// Byte-serial framer: deserialises alternating key (salt+password) and message
// bursts into blocks offered to the core over a valid/ready handshake.
module top_input_framer
  import top_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_data,
  input  logic              i_start,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_kind,
  output logic [SALT_W-1:0] o_salt,
  output logic [PW_W-1:0]   o_pw,
  output logic [MSG_W-1:0]  o_msg,
  output logic              o_ien,
  output logic              o_err,
  output logic              o_phase
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              valid_q, valid_d;
  logic              kind_q, kind_d;
  logic              err_q, err_d;
  logic              ien_q, ien_d;
  logic              err_done_q, err_done_d;
  logic [SALT_W-1:0] salt_q, salt_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic [MSG_W-1:0]  msg_q, msg_d;

  logic [CNT_W-1:0]  len_c, idx_c;
  logic              take_c, salt_en_c, pw_en_c, msg_en_c;
  logic [SALT_W-1:0] salt_nxt_c;
  logic [PW_W-1:0]   pw_nxt_c;
  logic [MSG_W-1:0]  msg_nxt_c;

  // Route each accepted byte to the shadow register for its position.
  always_comb begin
    len_c     = burst_len(phase_q);
    take_c    = i_start & ((state_q == IDLE) | (state_q == RECV));
    idx_c     = (state_q == IDLE) ? '0 : cnt_q;
    salt_en_c = take_c & (phase_q == KIND_KEY) & (idx_c < CNT_W'(SALT_BYTES));
    pw_en_c   = take_c & (phase_q == KIND_KEY) & (idx_c >= CNT_W'(SALT_BYTES));
    msg_en_c  = take_c & (phase_q != KIND_KEY);
  end

  byte_shift_reg #(.BYTES(SALT_BYTES)) u_salt (
    .clk(clk), .rst(rst), .en_i(salt_en_c), .din_i(i_data), .nxt_c(salt_nxt_c)
  );

  byte_shift_reg #(.BYTES(PW_BYTES)) u_pw (
    .clk(clk), .rst(rst), .en_i(pw_en_c), .din_i(i_data), .nxt_c(pw_nxt_c)
  );

  byte_shift_reg #(.BYTES(MSG_BYTES)) u_msg (
    .clk(clk), .rst(rst), .en_i(msg_en_c), .din_i(i_data), .nxt_c(msg_nxt_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    valid_d    = valid_q;
    kind_d     = kind_q;
    err_d      = 1'b0;
    err_done_d = err_done_q;
    salt_d     = salt_q;
    pw_d       = pw_q;
    msg_d      = msg_q;

    unique case (state_q)
      IDLE: begin
        err_done_d = 1'b0;
        if (i_start) begin
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (i_start) begin
          if (cnt_q == len_c - CNT_W'(1)) begin
            state_d = HOLD;
            cnt_d   = '0;
            valid_d = 1'b1;
            kind_d  = phase_q;
            if (phase_q == KIND_KEY) begin
              salt_d = salt_nxt_c;
              pw_d   = pw_nxt_c;
            end else begin
              msg_d  = msg_nxt_c;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          phase_d = ~phase_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Long-burst tails and bursts landing while a block is pending flag once per burst.
    if ((state_q == HOLD) || (state_q == WAIT)) begin
      if (i_start && !err_done_q) begin
        err_d      = 1'b1;
        err_done_d = 1'b1;
      end else if (!i_start) begin
        err_done_d = 1'b0;
      end
    end

    ien_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= KIND_KEY;
      valid_q    <= 1'b0;
      kind_q     <= KIND_KEY;
      err_q      <= 1'b0;
      ien_q      <= 1'b1;
      err_done_q <= 1'b0;
      salt_q     <= '0;
      pw_q       <= '0;
      msg_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      kind_q     <= kind_d;
      err_q      <= err_d;
      ien_q      <= ien_d;
      err_done_q <= err_done_d;
      salt_q     <= salt_d;
      pw_q       <= pw_d;
      msg_q      <= msg_d;
    end
  end

  assign o_valid = valid_q;
  assign o_kind  = kind_q;
  assign o_salt  = salt_q;
  assign o_pw    = pw_q;
  assign o_msg   = msg_q;
  assign o_ien   = ien_q;
  assign o_err   = err_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_top_input_framer.sv
// Directed self-checking bench for top_input_framer.
module tb_top_input_framer;

  logic         clk;
  logic         rst;
  logic [7:0]   i_data;
  logic         i_start;
  logic         i_ready;
  logic         o_valid;
  logic         o_kind;
  logic [127:0] o_salt;
  logic [119:0] o_pw;
  logic [127:0] o_msg;
  logic         o_ien;
  logic         o_err;
  logic         o_phase;

  int checks;
  int errors;
  int err_seen;
  int valid_seen;

  top_input_framer dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_start(i_start), .i_ready(i_ready),
    .o_valid(o_valid), .o_kind(o_kind), .o_salt(o_salt), .o_pw(o_pw), .o_msg(o_msg),
    .o_ien(o_ien), .o_err(o_err), .o_phase(o_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic observe();
    if (o_err)   err_seen++;
    if (o_valid) valid_seen++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      observe();
    end
  endtask

  // Drives n consecutive bytes base, base+1, ... then drops i_start.
  task automatic send_bytes(input int n, input logic [7:0] base);
    err_seen   = 0;
    valid_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      observe();
      i_start = 1'b1;
      i_data  = base + 8'(i);
    end
    @(negedge clk);
    observe();
    i_start = 1'b0;
    i_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_data = 8'h00; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_ien !== 1'b1)   begin errors++; $display("FAIL reset_ien got %b want 1", o_ien); end
    checks++; if (o_phase !== 1'b0) begin errors++; $display("FAIL reset_phase got %b want 0", o_phase); end
    checks++; if (o_err !== 1'b0 || o_kind !== 1'b0) begin errors++; $display("FAIL reset_err_kind got %b%b want 00", o_err, o_kind); end
    checks++; if (o_salt !== 128'h0 || o_pw !== 120'h0 || o_msg !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h want zeros", o_salt, o_pw, o_msg);
    end
  endtask

  task automatic test_key_burst();
    send_bytes(31, 8'h00);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL key_valid got %b want 1", o_valid); end
    checks++; if (o_kind !== 1'b0)  begin errors++; $display("FAIL key_kind got %b want 0", o_kind); end
    checks++; if (o_salt !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL key_salt got %h", o_salt); end
    checks++; if (o_pw !== 120'h101112131415161718191a1b1c1d1e) begin errors++; $display("FAIL key_pw got %h", o_pw); end
    checks++; if (o_ien !== 1'b0)   begin errors++; $display("FAIL key_ien_hold got %b want 0", o_ien); end
    step(1);
    checks++; if (o_valid !== 1'b0 || o_phase !== 1'b1) begin errors++; $display("FAIL key_xfer got valid=%b phase=%b want 0 1", o_valid, o_phase); end
    step(1);
    checks++; if (o_ien !== 1'b1)   begin errors++; $display("FAIL key_ien_back got %b want 1", o_ien); end
  endtask

  task automatic test_msg_burst();
    send_bytes(16, 8'hA0);
    checks++; if (o_valid !== 1'b1 || o_kind !== 1'b1) begin errors++; $display("FAIL msg_valid_kind got %b%b want 11", o_valid, o_kind); end
    checks++; if (o_msg !== 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf) begin errors++; $display("FAIL msg_data got %h", o_msg); end
    step(1);
    checks++; if (o_phase !== 1'b0 || o_ien !== 1'b0) begin errors++; $display("FAIL msg_after_xfer got phase=%b ien=%b want 0 0", o_phase, o_ien); end
    step(1);
    checks++; if (o_ien !== 1'b1)   begin errors++; $display("FAIL msg_ien_two_cycles got %b want 1", o_ien); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    send_bytes(31, 8'h40);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_ien !== 1'b0 ||
          o_salt !== 128'h404142434445464748494a4b4c4d4e4f || o_pw !== 120'h505152535455565758595a5b5c5d5e) begin
        errors++; $display("FAIL bp_hold cycle %0d got valid=%b ien=%b salt=%h pw=%h", i, o_valid, o_ien, o_salt, o_pw);
      end
      if (i < 4) step(1);
    end
    i_ready = 1'b1;
    step(1);
    checks++; if (o_valid !== 1'b0 || o_phase !== 1'b1) begin errors++; $display("FAIL bp_xfer got valid=%b phase=%b want 0 1", o_valid, o_phase); end
    valid_seen = 0;
    step(3);
    checks++; if (valid_seen !== 0 || o_phase !== 1'b1) begin errors++; $display("FAIL bp_single_xfer got valid_cycles=%0d phase=%b want 0 1", valid_seen, o_phase); end
  endtask

  task automatic test_long_burst();
    send_bytes(18, 8'hB0);
    checks++; if (valid_seen !== 1) begin errors++; $display("FAIL long_valid_cycles got %0d want 1", valid_seen); end
    checks++; if (err_seen !== 1)   begin errors++; $display("FAIL long_err_pulses got %0d want 1", err_seen); end
    checks++; if (o_ien !== 1'b0)   begin errors++; $display("FAIL long_ien_tail got %b want 0", o_ien); end
    checks++; if (o_msg !== 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf) begin errors++; $display("FAIL long_msg got %h", o_msg); end
    step(1);
    checks++; if (o_ien !== 1'b1 || o_phase !== 1'b0 || err_seen !== 1) begin
      errors++; $display("FAIL long_after got ien=%b phase=%b errs=%0d want 1 0 1", o_ien, o_phase, err_seen);
    end
  endtask

  task automatic test_short_burst();
    send_bytes(20, 8'hC0);
    step(3);
    checks++; if (err_seen !== 1)   begin errors++; $display("FAIL short_err_pulses got %0d want 1", err_seen); end
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL short_valid got %0d want 0", valid_seen); end
    checks++; if (o_phase !== 1'b0 || o_ien !== 1'b1) begin errors++; $display("FAIL short_phase_ien got %b %b want 0 1", o_phase, o_ien); end
    checks++; if (o_salt !== 128'h404142434445464748494a4b4c4d4e4f) begin errors++; $display("FAIL short_salt_kept got %h", o_salt); end
    send_bytes(31, 8'h60);
    checks++; if (o_valid !== 1'b1 || o_kind !== 1'b0 ||
                  o_salt !== 128'h606162636465666768696a6b6c6d6e6f || o_pw !== 120'h707172737475767778797a7b7c7d7e) begin
      errors++; $display("FAIL short_recover got valid=%b kind=%b salt=%h pw=%h", o_valid, o_kind, o_salt, o_pw);
    end
    checks++; if (err_seen !== 0)   begin errors++; $display("FAIL short_recover_err got %0d want 0", err_seen); end
    step(2);
  endtask

  task automatic test_back_to_back_msg();
    send_bytes(16, 8'hD0);
    checks++; if (o_valid !== 1'b1 || o_kind !== 1'b1 || o_msg !== 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf) begin
      errors++; $display("FAIL b2b_msg got valid=%b kind=%b msg=%h", o_valid, o_kind, o_msg);
    end
    step(2);
    checks++; if (o_phase !== 1'b0 || o_ien !== 1'b1) begin errors++; $display("FAIL b2b_idle got phase=%b ien=%b want 0 1", o_phase, o_ien); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_start = 1'b1;
      i_data  = 8'h80 + 8'(i);
    end
    @(negedge clk);
    checks++; if (o_ien !== 1'b0)   begin errors++; $display("FAIL arst_pre_ien got %b want 0", o_ien); end
    #2;
    rst = 1'b1;
    i_start = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_ien !== 1'b1 || o_phase !== 1'b0 || o_err !== 1'b0 || o_kind !== 1'b0) begin
      errors++; $display("FAIL arst_ctrl got valid=%b ien=%b phase=%b err=%b kind=%b want 0 1 0 0 0", o_valid, o_ien, o_phase, o_err, o_kind);
    end
    checks++; if (o_salt !== 128'h0 || o_pw !== 120'h0 || o_msg !== 128'h0) begin
      errors++; $display("FAIL arst_data got %h %h %h want zeros", o_salt, o_pw, o_msg);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1);
    send_bytes(31, 8'hE0);
    checks++; if (o_valid !== 1'b1 || o_kind !== 1'b0 ||
                  o_salt !== 128'he0e1e2e3e4e5e6e7e8e9eaebecedeeef || o_pw !== 120'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe) begin
      errors++; $display("FAIL arst_recover got valid=%b kind=%b salt=%h pw=%h", o_valid, o_kind, o_salt, o_pw);
    end
    step(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    err_seen = 0;
    valid_seen = 0;
    test_reset();
    test_key_burst();
    test_msg_burst();
    test_backpressure();
    test_long_burst();
    test_short_burst();
    test_back_to_back_msg();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
